// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO and a sticky
// overflow flag. DATA (addr[2]=0) stores enqueue a byte; STATUS (addr[2]=1)
// loads return count/overflow/full/busy and clear overflow.
module uart_tx #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    fifo_mem [DEPTH];

  logic push, push_ok, pop, baud_done, frame_end, ovf_clr, full, busy;
  logic [7:0] count8;
  logic unused_bits;

  assign unused_bits = ^{addr[31:3], addr[1:0], din[31:8]};
  assign tx = tx_q;

  // Push/pop qualification and FIFO bookkeeping
  always_comb begin
    push      = sel & we & ~addr[2];
    baud_done = (baud_q == BAUD_LAST);
    frame_end = (state_q == S_STOP) & baud_done;
    // The end of a stop bit counts as entering IDLE, so the next byte is
    // popped on that same edge and frames run back to back.
    pop       = (count_q != '0) & ((state_q == S_IDLE) | frame_end);
    push_ok   = push & ((count_q != COUNT_FULL) | pop);
    ovf_clr   = sel & re & addr[2];
    wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    ovf_d     = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push & ~push_ok) ovf_d = 1'b1;
  end

  // Transmit FSM: each line bit held for DIV cycles of the baud counter
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          baud_d  = '0;
          shift_d = fifo_mem[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        if (baud_done) begin
          baud_d = '0;
          if (pop) begin
            state_d = S_START;
            shift_d = fifo_mem[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase
  end

  // Status word / load data, combinational from addr[2]
  always_comb begin
    full   = (count_q == COUNT_FULL);
    busy   = (state_q != S_IDLE) | (count_q != '0);
    count8 = 8'(count_q);
    dout   = '0;
    if (addr[2]) dout = {16'h0, count8, 5'h0, ovf_q, full, busy};
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage write port; contents need no reset
  always_ff @(posedge clock) begin
    if (!reset && push_ok) fifo_mem[wr_ptr_q] <= din[7:0];
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a frame-schedule reference model checked every cycle,
// a vector table for the register-access corner cases, hand sequences for the
// multi-cycle cases and a randomized traffic phase.
module tb_uart_tx;

  localparam int unsigned D     = 16;
  localparam int unsigned DEP   = 16;
  localparam int unsigned FRAME = 10 * D;
  localparam int unsigned NS    = 16384;

  logic        clock = 1'b0;
  logic        reset, sel, we, re, tx;
  logic [31:0] addr, din, dout;

  uart_tx #(.CLK_HZ(16), .BAUD(1), .DEPTH(DEP)) dut (
    .clock(clock), .reset(reset), .sel(sel), .we(we), .re(re),
    .addr(addr), .din(din), .dout(dout), .tx(tx)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] b; int unsigned start; } ent_t;
  typedef struct {
    logic s; logic w; logic r; logic [31:0] a; logic [7:0] d;
    logic [31:0] exp_st; logic exp_tx;
  } vec_t;

  // Reference model: each accepted byte is scheduled a frame start time
  ent_t        pend[$];
  bit          cur_v = 0;
  int unsigned cur_s = 0;
  logic [7:0]  cur_b = '0;
  int unsigned last_end = 0;
  bit          m_ovf = 0;

  int unsigned cyc = 0;
  logic        samp_tx [NS];
  logic [31:0] samp_st [NS];
  int          checks = 0;
  int          errors = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic w, input logic rd,
                      input logic [31:0] a, input logic [7:0] d);
    int unsigned cnt_b, bi, cnt;
    bit popn, pushn, active;
    ent_t e;
    logic exp_tx;
    logic [31:0] exp_st;
    reset = r; sel = s; we = w; re = rd; addr = a;
    din = ($urandom & 32'hFFFF_FF00) | {24'h0, d};
    @(posedge clock);
    cyc++;
    if (r) begin
      pend.delete(); cur_v = 0; last_end = 0; m_ovf = 0;
    end else begin
      popn  = (pend.size() != 0) && (pend[0].start == cyc);
      cnt_b = pend.size();
      if (popn) begin
        cur_v = 1; cur_s = cyc; cur_b = pend[0].b;
        void'(pend.pop_front());
      end
      if (s && rd && a[2]) m_ovf = 0;
      pushn = s && w && !a[2];
      if (pushn) begin
        if (cnt_b < DEP || popn) begin
          e.b = d;
          e.start = (cyc + 1 > last_end) ? cyc + 1 : last_end;
          last_end = e.start + FRAME;
          pend.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
    end
    #1;
    reset = 1'b0; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 32'h4;
    #1;
    cnt = pend.size();
    active = cur_v && (cyc < cur_s + FRAME);
    exp_tx = 1'b1;
    if (active) begin
      bi = (cyc - cur_s) / D;
      if (bi == 0) exp_tx = 1'b0;
      else if (bi < 9) exp_tx = cur_b[bi-1];
    end
    exp_st = {16'h0, 8'(cnt), 5'h0, m_ovf, (cnt == DEP), (active || cnt != 0)};
    check32("model_tx", {31'h0, tx}, {31'h0, exp_tx});
    check32("model_status", dout, exp_st);
    if (cyc < NS) begin
      samp_tx[cyc] = tx;
      samp_st[cyc] = dout;
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  task automatic decode(input int unsigned fs, input logic [7:0] exp, input string nm);
    logic [7:0] b;
    b = '0;
    if (fs + FRAME >= NS) begin
      check32({nm, "_range"}, fs, 0);
    end else begin
      check32({nm, "_start"}, {31'h0, samp_tx[fs]}, 32'h0);
      for (int unsigned j = 0; j < 8; j++) b[j] = samp_tx[fs + D * (j + 1) + D / 2];
      check32({nm, "_byte"}, {24'h0, b}, {24'h0, exp});
      check32({nm, "_stop"}, {31'h0, samp_tx[fs + 9 * D + D / 2]}, 32'h1);
    end
  endtask

  initial begin
    int unsigned b1, b2, p, r;
    logic [7:0] wbytes [18];
    vec_t tbl [6];

    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 8'hAA, 32'h0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0004, 8'hBB, 32'h0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h1000_0000, 8'hCC, 32'h0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 8'hDD, 32'h0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0007, 8'hEE, 32'h0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0003, 8'h5A, 32'h101, 1'b1};

    reset = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 32'h4; din = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    check32("reset_tx", {31'h0, tx}, 32'h1);
    check32("reset_status", dout, 32'h0);

    // Single 0x55 frame
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h55);
    b1 = cyc;
    idle(170);
    check32("t1_tx_push_edge", {31'h0, samp_tx[b1]}, 32'h1);
    check32("t1_tx_start_first", {31'h0, samp_tx[b1 + 1]}, 32'h0);
    check32("t1_tx_start_last", {31'h0, samp_tx[b1 + 16]}, 32'h0);
    check32("t1_tx_bit0", {31'h0, samp_tx[b1 + 17]}, 32'h1);
    check32("t1_tx_bit1", {31'h0, samp_tx[b1 + 33]}, 32'h0);
    decode(b1 + 1, 8'h55, "t1");
    check32("t1_busy_last", {31'h0, samp_st[b1 + 160][0]}, 32'h1);
    check32("t1_busy_clear", {31'h0, samp_st[b1 + 161][0]}, 32'h0);

    // Burst of 18 stores overflows a 16-deep FIFO
    for (int i = 0; i < 18; i++) wbytes[i] = 8'($urandom);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, wbytes[i]);
      if (i == 0) b2 = cyc;
    end
    check32("t2_status_full_ovf", dout, 32'h0000_1007);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 8'h00);
    check32("t3_ovf_cleared", dout, 32'h0000_1003);
    while (cyc < b2 + 1 + 17 * FRAME + 4) idle(1);
    for (int unsigned f = 0; f < 17; f++) decode(b2 + 1 + f * FRAME, wbytes[f], "t3_drain");
    check32("t3_busy_before_end", {31'h0, samp_st[b2 + 17 * FRAME][0]}, 32'h1);
    check32("t3_idle_after_drain", samp_st[b2 + 1 + 17 * FRAME], 32'h0);

    // Store into a full FIFO on the edge a frame-boundary pop happens
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 8'(i + 8'h40));
      if (i == 0) p = cyc;
    end
    check32("t4_full_before", dout, 32'h0000_1003);
    while (cyc < p + 160) idle(1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h3C);
    check32("t4_push_on_pop", dout, 32'h0000_1003);

    // Reset in the middle of data bit 3
    while (cyc < p + 161 + 69) idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    check32("t5_reset_tx", {31'h0, tx}, 32'h1);
    check32("t5_reset_status", dout, 32'h0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 8'hA3);
    r = cyc;
    idle(165);
    decode(r + 1, 8'hA3, "t5_clean");

    // Register-access vectors from idle/empty
    foreach (tbl[i]) begin
      sel = tbl[i].s; we = tbl[i].w; re = tbl[i].r; addr = tbl[i].a;
      #1;
      if (!tbl[i].a[2]) check32("tbl_data_read", dout, 32'h0);
      step(1'b0, tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      check32("tbl_status", dout, tbl[i].exp_st);
      check32("tbl_tx", {31'h0, tx}, {31'h0, tbl[i].exp_tx});
    end
    idle(170);

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 3000; i++) begin
      int unsigned k;
      logic [31:0] ra;
      k = $urandom_range(0, 99);
      ra = $urandom & 32'hFFFF_FFFB;
      if (k < 12)      step(1'b0, 1'b1, 1'b1, 1'b0, ra, 8'($urandom));
      else if (k < 15) step(1'b0, 1'b0, 1'b1, 1'b0, ra, 8'($urandom));
      else if (k < 18) step(1'b0, 1'b1, 1'b1, 1'b0, ra | 32'h4, 8'($urandom));
      else if (k < 22) step(1'b0, 1'b1, 1'b0, 1'b1, ra | 32'h4, 8'h00);
      else if (k < 24) step(1'b0, 1'b1, 1'b0, 1'b1, ra, 8'h00);
      else             step(1'b0, 1'b0, 1'b0, 1'b0, ra, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
